// File: rtl/ff_bank.sv
// ff_bank: a bank of WIDTH storage bits. All bits follow one next-state
// rule, chosen at run time: D, T, JK or SR. The bank also provides a
// synchronous parallel load, a registered per-bit change mask, a
// saturating change counter and a sticky flag for illegal SR pairs.
//
// Ports:
//   clk      - rising-edge clock
//   rst      - asynchronous, active-high reset
//   en       - update enable for the mode rule
//   mode     - 00 = D, 01 = T, 10 = JK, 11 = SR
//   a        - D / T / J / S per bit
//   b        - K / R per bit; ignored in D and T modes
//   load     - synchronous parallel load; has priority over en
//   load_val - value loaded when load = 1
//   clr      - synchronous clear of chg_cnt and sr_err
//   q        - stored state
//   q_bar    - ~q, combinational from q
//   changed  - bits of q that changed at the last edge
//   chg_cnt  - saturating count of bit changes
//   sr_err   - sticky: an S = R = 1 pair was applied in SR mode
module ff_bank #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             clr,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] q_bar,
    output logic [WIDTH-1:0] changed,
    output logic [CNT_W-1:0] chg_cnt,
    output logic             sr_err
);

    typedef enum logic [1:0] {
        MODE_D  = 2'b00,
        MODE_T  = 2'b01,
        MODE_JK = 2'b10,
        MODE_SR = 2'b11
    } mode_e;

    // The popcount of up to 32 bits needs 6 bits. The sum needs one extra
    // bit beyond the wider operand, so the saturation test sees the true
    // total and never a wrapped value.
    localparam int unsigned POP_W = 6;
    localparam int unsigned SUM_W = ((CNT_W > POP_W) ? CNT_W : POP_W) + 1;
    localparam logic [SUM_W-1:0] CNT_MAX = SUM_W'({CNT_W{1'b1}});

    logic [WIDTH-1:0] state_q, state_d;
    logic [WIDTH-1:0] chg_q,   chg_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic             err_q,   err_d;

    mode_e            mode_s;
    logic [WIDTH-1:0] rule_n;
    logic [WIDTH-1:0] diff;
    logic [POP_W-1:0] pop;
    logic [SUM_W-1:0] sum;
    logic             sr_set;

    always_comb begin
        mode_s = mode_e'(mode);
        rule_n = state_q;
        unique case (mode_s)
            MODE_D:  rule_n = a;
            MODE_T:  rule_n = state_q ^ a;
            // JK: set where J, clear where K, toggle where both are high.
            MODE_JK: rule_n = (a & ~state_q) | (~b & state_q);
            // SR: an S = R = 1 pair holds the bit.
            MODE_SR: rule_n = (a & ~b) | (state_q & ~(a ^ b)) | (state_q & a & b);
            default: rule_n = state_q;
        endcase
    end

    always_comb begin
        if (load) begin
            state_d = load_val;
        end else if (en) begin
            state_d = rule_n;
        end else begin
            state_d = state_q;
        end

        diff  = state_d ^ state_q;
        chg_d = diff;

        pop = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            pop = pop + {{(POP_W-1){1'b0}}, diff[i]};
        end

        sum = SUM_W'(cnt_q) + SUM_W'(pop);
        if (clr) begin
            cnt_d = '0;
        end else if (sum > CNT_MAX) begin
            cnt_d = '1;
        end else begin
            cnt_d = sum[CNT_W-1:0];
        end

        // If a set condition and clr occur in the same cycle, the set wins.
        sr_set = !load && en && (mode_s == MODE_SR) && (|(a & b));
        err_d  = sr_set | (err_q & ~clr);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= '0;
            chg_q   <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            chg_q   <= chg_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    assign q       = state_q;
    assign q_bar   = ~state_q;
    assign changed = chg_q;
    assign chg_cnt = cnt_q;
    assign sr_err  = err_q;

endmodule
